// File: rtl/tmr_mon_pkg.sv
// tmr_mon_pkg: shared types and sizes for the TMR fault monitor
package tmr_mon_pkg;
   typedef enum logic [1:0] {ST_OK, ST_SUSPECT, ST_FAILED} state_e;
   typedef enum logic {EV_ONSET, EV_FAILED} kind_e;
   typedef logic [1:0] replica_t;
   localparam int NUM_REPLICAS = 3;
   localparam int NUM_SLOTS = 2 * NUM_REPLICAS;
endpackage

// File: rtl/tmr_evt_fifo.sv
// tmr_evt_fifo: show-ahead event FIFO with full/empty flags and synchronous clear
module tmr_evt_fifo #(
   parameter int W = 19,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clear_i,
   input  logic         push_i,
   input  logic [W-1:0] data_i,
   input  logic         pop_i,
   output logic [W-1:0] data_o,
   output logic         full_o,
   output logic         empty_o
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [AW:0] cnt_q, cnt_d;
   logic push, pop;
   assign full_o = cnt_q == (AW+1)'(DEPTH);
   assign empty_o = cnt_q == '0;
   assign data_o = mem_q[rd_q];
   always_comb begin
      push = push_i & ~full_o & ~clear_i;
      pop = pop_i & ~empty_o & ~clear_i;
      wr_d = clear_i ? '0 : wr_q + AW'(push);
      rd_d = clear_i ? '0 : rd_q + AW'(pop);
      cnt_d = clear_i ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(pop);
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wr_q <= '0;
         rd_q <= '0;
         cnt_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
         cnt_q <= cnt_d;
      end
   always_ff @(posedge clk)
      if (push) mem_q[wr_q] <= data_i;
endmodule

// File: rtl/tmr_fault_monitor.sv
// tmr_fault_monitor: per-replica fault classification, error counting and timestamped event stream
module tmr_fault_monitor
   import tmr_mon_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int ERR_W = 8,
   parameter int PERSIST = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [2:0]           fault_i,
   input  logic [WIDTH-1:0]     voted_q_i,
   input  logic                 clear_i,
   output logic                 evt_valid_o,
   input  logic                 evt_ready_i,
   output logic [1:0]           evt_replica_o,
   output logic                 evt_kind_o,
   output logic [WIDTH-1:0]     evt_stamp_o,
   output logic [3*ERR_W-1:0]   err_cnt_o,
   output logic [2:0]           failed_o,
   output logic                 overflow_o
);
   localparam int EW = 3 + WIDTH;
   logic [NUM_SLOTS-1:0] raise, pending_q, pending_d, take;
   logic [NUM_SLOTS-1:0][WIDTH-1:0] stamp_q, stamp_d;
   logic overflow_q, overflow_d;
   logic [2:0] sel;
   logic found, push, full, empty;
   logic [EW-1:0] head;
   for (genvar n = 0; n < NUM_REPLICAS; n++) begin : g_rep
      state_e state_q, state_d;
      logic [3:0] run_q, run_d;
      logic [ERR_W-1:0] err_q, err_d;
      logic flt;
      always_comb begin
         flt = fault_i[n] & ~clear_i;
         err_d = clear_i ? '0 : err_q + ERR_W'(flt && err_q != '1);
         state_d = clear_i ? ST_OK :
                   state_q == ST_FAILED ? ST_FAILED :
                   !flt ? ST_OK :
                   (state_q == ST_SUSPECT && run_q == 4'(PERSIST - 1)) ? ST_FAILED : ST_SUSPECT;
         run_d = clear_i ? '0 : state_q == ST_FAILED ? run_q : !flt ? '0 : run_q + 4'd1;
      end
      assign raise[2*n] = flt & (state_q == ST_OK);
      assign raise[2*n+1] = flt & (state_q == ST_SUSPECT) & (run_q == 4'(PERSIST - 1));
      assign failed_o[n] = state_q == ST_FAILED;
      assign err_cnt_o[n*ERR_W +: ERR_W] = err_q;
      always_ff @(posedge clk or posedge rst)
         if (rst) begin
            state_q <= ST_OK;
            run_q <= '0;
            err_q <= '0;
         end else begin
            state_q <= state_d;
            run_q <= run_d;
            err_q <= err_d;
         end
   end
   // slot index is {replica, kind}; a slot drained this cycle is free for a new raise
   always_comb begin
      sel = '0;
      found = 1'b0;
      for (int r = 0; r < NUM_REPLICAS; r++)
         for (int k = 1; k >= 0; k--)
            if (!found && pending_q[2*r+k]) begin
               sel = 3'(2*r+k);
               found = 1'b1;
            end
      push = found & ~full & ~clear_i;
      take = push ? NUM_SLOTS'(1) << sel : '0;
      pending_d = clear_i ? '0 : (pending_q & ~take) | raise;
      overflow_d = ~clear_i & (overflow_q | (|(raise & pending_q & ~take)));
      for (int s = 0; s < NUM_SLOTS; s++)
         stamp_d[s] = (raise[s] && (!pending_q[s] || take[s])) ? voted_q_i : stamp_q[s];
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         pending_q <= '0;
         stamp_q <= '0;
         overflow_q <= 1'b0;
      end else begin
         pending_q <= pending_d;
         stamp_q <= stamp_d;
         overflow_q <= overflow_d;
      end
   tmr_evt_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .clear_i (clear_i),
      .push_i  (push),
      .data_i  ({sel[2:1], sel[0], stamp_q[sel]}),
      .pop_i   (evt_ready_i),
      .data_o  (head),
      .full_o  (full),
      .empty_o (empty)
   );
   assign evt_valid_o = ~empty;
   assign evt_replica_o = empty ? '0 : head[EW-1 -: 2];
   assign evt_kind_o = ~empty & head[WIDTH];
   assign evt_stamp_o = empty ? '0 : head[WIDTH-1:0];
   assign overflow_o = overflow_q;
endmodule

// File: tb/tb_tmr_fault_monitor.sv
// tb_tmr_fault_monitor: directed and random checks of the fault monitor against a queue-based model
module tb_tmr_fault_monitor;
   localparam int WIDTH = 16;
   localparam int ERR_W = 8;
   localparam int PERSIST = 4;
   localparam int DEPTH = 4;
   localparam int ERR_MAX = (1 << ERR_W) - 1;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [2:0] fault_i = '0;
   logic [WIDTH-1:0] voted_q_i = '0;
   logic clear_i = 1'b0;
   logic evt_ready_i = 1'b0;
   logic evt_valid_o;
   logic [1:0] evt_replica_o;
   logic evt_kind_o;
   logic [WIDTH-1:0] evt_stamp_o;
   logic [3*ERR_W-1:0] err_cnt_o;
   logic [2:0] failed_o;
   logic overflow_o;
   int tests = 0;
   int fails = 0;
   always #5 clk = ~clk;
   tmr_fault_monitor #(.WIDTH(WIDTH), .ERR_W(ERR_W), .PERSIST(PERSIST), .FIFO_DEPTH(DEPTH)) dut (
      .clk           (clk),
      .rst           (rst),
      .fault_i       (fault_i),
      .voted_q_i     (voted_q_i),
      .clear_i       (clear_i),
      .evt_valid_o   (evt_valid_o),
      .evt_ready_i   (evt_ready_i),
      .evt_replica_o (evt_replica_o),
      .evt_kind_o    (evt_kind_o),
      .evt_stamp_o   (evt_stamp_o),
      .err_cnt_o     (err_cnt_o),
      .failed_o      (failed_o),
      .overflow_o    (overflow_o)
   );
   typedef struct packed {logic [1:0] r; logic k; logic [WIDTH-1:0] s;} ev_t;
   ev_t q[$];
   int run[3];
   int err[3];
   bit dead[3];
   bit pend[6];
   logic [WIDTH-1:0] pst[6];
   bit ovf;
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic model_reset();
      for (int n = 0; n < 3; n++) begin
         run[n] = 0;
         err[n] = 0;
         dead[n] = 0;
      end
      for (int s = 0; s < 6; s++) begin
         pend[s] = 0;
         pst[s] = '0;
      end
      q.delete();
      ovf = 0;
   endtask
   task automatic raise_evt(input int s, input logic [WIDTH-1:0] v);
      if (pend[s]) ovf = 1;
      else begin
         pend[s] = 1;
         pst[s] = v;
      end
   endtask
   task automatic model_edge(input logic [2:0] f, input logic [WIDTH-1:0] v, input logic c, input logic rd);
      int sel;
      bit was_full;
      if (c) begin
         model_reset();
         return;
      end
      sel = -1;
      was_full = q.size() >= DEPTH;
      for (int r = 0; r < 3; r++)
         for (int k = 1; k >= 0; k--)
            if (sel < 0 && pend[2*r+k]) sel = 2*r + k;
      if (rd && q.size() > 0) q.delete(0);
      if (sel >= 0 && !was_full) begin
         q.push_back({2'(sel / 2), 1'(sel % 2), pst[sel]});
         pend[sel] = 0;
      end
      for (int n = 0; n < 3; n++) begin
         if (f[n]) begin
            err[n] = err[n] < ERR_MAX ? err[n] + 1 : ERR_MAX;
            if (!dead[n]) begin
               run[n]++;
               if (run[n] == 1) raise_evt(2*n, v);
               if (run[n] == PERSIST) begin
                  dead[n] = 1;
                  raise_evt(2*n+1, v);
               end
            end
         end else if (!dead[n]) run[n] = 0;
      end
   endtask
   task automatic check_all();
      ev_t h;
      h = q.size() > 0 ? q[0] : '0;
      chk("valid", 64'(evt_valid_o), 64'(q.size() > 0));
      chk("replica", 64'(evt_replica_o), 64'(h.r));
      chk("kind", 64'(evt_kind_o), 64'(h.k));
      chk("stamp", 64'(evt_stamp_o), 64'(h.s));
      chk("err_cnt", 64'(err_cnt_o), 64'({8'(err[2]), 8'(err[1]), 8'(err[0])}));
      chk("failed", 64'(failed_o), 64'({dead[2], dead[1], dead[0]}));
      chk("overflow", 64'(overflow_o), 64'(ovf));
   endtask
   task automatic step(input logic [2:0] f, input logic [WIDTH-1:0] v, input logic c, input logic rd);
      fault_i = f;
      voted_q_i = v;
      clear_i = c;
      evt_ready_i = rd;
      @(posedge clk);
      model_edge(f, v, c, rd);
      #1;
      check_all();
   endtask
   task automatic expect_evt(input logic [1:0] r, input logic k, input logic [WIDTH-1:0] s);
      int n;
      n = 0;
      while (!evt_valid_o && n < 8) begin
         step(3'b000, '0, 1'b0, 1'b0);
         n++;
      end
      chk("evt_wait", 64'(evt_valid_o), 64'(1));
      chk("evt_replica", 64'(evt_replica_o), 64'(r));
      chk("evt_kind", 64'(evt_kind_o), 64'(k));
      chk("evt_stamp", 64'(evt_stamp_o), 64'(s));
      step(3'b000, '0, 1'b0, 1'b1);
   endtask
   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all();
      rst = 1'b0;
      step(3'b010, 16'h0010, 1'b0, 1'b0);
      chk("t1_err1", 64'(err_cnt_o[15:8]), 64'(1));
      chk("t1_not_yet", 64'(evt_valid_o), 64'(0));
      step(3'b000, 16'h0011, 1'b0, 1'b0);
      chk("t1_latency", 64'(evt_valid_o), 64'(1));
      expect_evt(2'd1, 1'b0, 16'h0010);
      chk("t1_failed", 64'(failed_o), 64'(0));
      for (int i = 0; i < 4; i++) step(3'b100, 16'(16'h0020 + i), 1'b0, 1'b0);
      chk("t2_failed", 64'(failed_o), 64'(3'b100));
      chk("t2_err2", 64'(err_cnt_o[23:16]), 64'(4));
      expect_evt(2'd2, 1'b0, 16'h0020);
      expect_evt(2'd2, 1'b1, 16'h0023);
      step(3'b000, '0, 1'b1, 1'b0);
      step(3'b111, 16'h0040, 1'b0, 1'b0);
      expect_evt(2'd0, 1'b0, 16'h0040);
      expect_evt(2'd1, 1'b0, 16'h0040);
      expect_evt(2'd2, 1'b0, 16'h0040);
      step(3'b000, '0, 1'b1, 1'b0);
      for (int i = 0; i < 6; i++) begin
         step(3'b001, 16'(16'h0100 + i), 1'b0, 1'b0);
         step(3'b000, '0, 1'b0, 1'b0);
      end
      chk("t4_overflow", 64'(overflow_o), 64'(1));
      for (int i = 0; i < 5; i++) begin
         chk("t4_drain_valid", 64'(evt_valid_o), 64'(1));
         chk("t4_drain_stamp", 64'(evt_stamp_o), 64'(16'h0100 + i));
         step(3'b000, '0, 1'b0, 1'b1);
      end
      chk("t4_empty", 64'(evt_valid_o), 64'(0));
      step(3'b000, '0, 1'b1, 1'b1);
      for (int i = 1; i <= 300; i++) begin
         step(3'b001, 16'(i), 1'b0, 1'b1);
         if (i == 3) chk("t5_not_failed", 64'(failed_o[0]), 64'(0));
         if (i == 4) chk("t5_failed", 64'(failed_o[0]), 64'(1));
      end
      chk("t5_sat", 64'(err_cnt_o[7:0]), 64'(255));
      step(3'b001, 16'h0999, 1'b0, 1'b1);
      chk("t5_sat_hold", 64'(err_cnt_o[7:0]), 64'(255));
      step(3'b001, 16'h0055, 1'b1, 1'b1);
      chk("t6_clear_err", 64'(err_cnt_o), 64'(0));
      repeat (3) step(3'b000, '0, 1'b0, 1'b1);
      chk("t6_no_evt", 64'(evt_valid_o), 64'(0));
      step(3'b111, 16'h0077, 1'b0, 1'b0);
      repeat (3) step(3'b000, '0, 1'b0, 1'b0);
      chk("t7_held", 64'(evt_valid_o), 64'(1));
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      check_all();
      chk("t7_rst_valid", 64'(evt_valid_o), 64'(0));
      #1;
      rst = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         int pct;
         logic [2:0] f;
         pct = (i / 250) % 4 == 0 ? 5 : (i / 250) % 4 == 1 ? 30 : (i / 250) % 4 == 2 ? 70 : 95;
         for (int b = 0; b < 3; b++) f[b] = $urandom_range(0, 99) < pct;
         step(f, 16'($urandom), $urandom_range(0, 199) == 0, $urandom_range(0, 99) < 60);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
